seq_range_sched: RTL and testbench

Hardware scheduler for the SVA range-delay sequence `a ##[MIN_DLY:MAX_DLY] b`, evaluated with overlapping attempts. Every cycle where `a` holds starts a new attempt. Each attempt occupies one of `SLOTS` tracking slots until it matches (first `b` inside the window) or fails (window expires). The block sits beside the assertion-lowering datapath as the resource manager for concurrent sequence attempts, covering allocation, aging, retirement, overflow and `disable iff` abort.

---
 rtl/seq_sched_pkg.sv | 28 ++
 rtl/seq_slot_alloc.sv | 28 ++
 rtl/seq_range_sched.sv | 107 ++++++++++
 tb/tb_seq_range_sched.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seq_sched_pkg.sv
// Shared types for the range-delay sequence scheduler.
// Slot record, per-slot result code and parameter sanity check.
package seq_sched_pkg;

  localparam int SLOT_K_W = 8;

  typedef struct packed {
    logic                active;
    logic [SLOT_K_W-1:0] k;
  } slot_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_MATCH,
    RES_FAIL
  } res_t;

  function automatic bit sched_params_ok(
    input int min_dly,
    input int max_dly,
    input int slots,
    input int cnt_w
  );
    return (min_dly >= 1) && (max_dly >= min_dly) &&
           (slots >= 1) && (cnt_w <= SLOT_K_W);
  endfunction

endpackage

// File: rtl/seq_slot_alloc.sv
// Find-first-free slot picker.
// One-hot grant of the lowest free slot when a start is requested.
module seq_slot_alloc #(
  parameter int N = 4
) (
  input  logic         req,
  input  logic [N-1:0] free,
  output logic [N-1:0] grant,
  output logic         none_free
);

  logic taken;

  // lowest-index free slot wins
  always_comb begin
    grant = '0;
    taken = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req && free[i] && !taken) begin
        grant[i] = 1'b1;
        taken    = 1'b1;
      end
    end
  end

  assign none_free = ~|free;

endmodule

// File: rtl/seq_range_sched.sv
// Slot scheduler for overlapping a ##[MIN_DLY:MAX_DLY] b attempts.
// Each start takes a slot that ages until match or window expiry.
module seq_range_sched
  import seq_sched_pkg::*;
#(
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 2,
  parameter int SLOTS   = 4,
  parameter int CNT_W   = $clog2(MAX_DLY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             abort,
  output logic [SLOTS-1:0] active,
  output logic [SLOTS-1:0] match_vec,
  output logic [SLOTS-1:0] fail_vec,
  output logic             match,
  output logic             fail,
  output logic             overflow
);

  if (!sched_params_ok(MIN_DLY, MAX_DLY, SLOTS, CNT_W)) begin : g_bad
    $error("seq_range_sched: illegal MIN_DLY/MAX_DLY/SLOTS");
  end

  logic             live;
  logic             req;
  logic [SLOTS-1:0] retire;
  logic [SLOTS-1:0] free;
  logic [SLOTS-1:0] grant;
  logic [SLOTS-1:0] m_nxt;
  logic [SLOTS-1:0] f_nxt;
  logic             none_free;

  assign live = en & ~abort;
  assign req  = live & a;
  assign free = ~active | retire;

  seq_slot_alloc #(
    .N(SLOTS)
  ) u_alloc (
    .req      (req),
    .free     (free),
    .grant    (grant),
    .none_free(none_free)
  );

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    slot_t st;
    res_t  res;
    int    age;

    assign active[i] = st.active;
    assign retire[i] = (res != RES_NONE);
    assign m_nxt[i]  = (res == RES_MATCH);
    assign f_nxt[i]  = (res == RES_FAIL);

    // decide match / expiry from the age this edge would reach
    always_comb begin
      res = RES_NONE;
      age = int'(st.k) + 1;
      if (st.active && live) begin
        if (b && age >= MIN_DLY && age <= MAX_DLY)
          res = RES_MATCH;
        else if (age == MAX_DLY)
          res = RES_FAIL;
      end
    end

    // slot lifecycle: allocate, age, retire, abort
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st <= '0;
      end else if (en) begin
        if (abort)
          st <= '0;
        else if (grant[i])
          st <= '{active: 1'b1, k: '0};
        else if (retire[i])
          st <= '0;
        else if (st.active)
          st.k <= st.k + SLOT_K_W'(1);
      end
    end
  end

  // registered result pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_vec <= '0;
      fail_vec  <= '0;
      match     <= 1'b0;
      fail      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      match_vec <= m_nxt;
      fail_vec  <= f_nxt;
      match     <= |m_nxt;
      fail      <= |f_nxt;
      overflow  <= req & none_free;
    end
  end

endmodule

// File: tb/tb_seq_range_sched.sv
// Scoreboard bench for seq_range_sched.
// Attempt-list reference model vs. DUT, directed then random.
module tb_seq_range_sched;

  localparam int MIN_DLY = 2;
  localparam int MAX_DLY = 4;
  localparam int SLOTS   = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             a = 1'b0;
  logic             b = 1'b0;
  logic             abort = 1'b0;
  logic [SLOTS-1:0] active;
  logic [SLOTS-1:0] match_vec;
  logic [SLOTS-1:0] fail_vec;
  logic             match;
  logic             fail;
  logic             overflow;

  typedef struct packed {
    logic [SLOTS-1:0] act;
    logic [SLOTS-1:0] mv;
    logic [SLOTS-1:0] fv;
    logic             m;
    logic             f;
    logic             ov;
  } obs_t;

  obs_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  int start_tick[SLOTS];
  int tick = 0;

  seq_range_sched #(
    .MIN_DLY(MIN_DLY),
    .MAX_DLY(MAX_DLY),
    .SLOTS  (SLOTS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .a        (a),
    .b        (b),
    .abort    (abort),
    .active   (active),
    .match_vec(match_vec),
    .fail_vec (fail_vec),
    .match    (match),
    .fail     (fail),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // each attempt is remembered by the enabled-cycle tick it started on
  function automatic obs_t model_step(
    input logic r, input logic e, input logic sa,
    input logic sb, input logic ab
  );
    obs_t o;
    int   age;
    bit   placed;
    o = '0;
    if (!r || (e && ab)) begin
      for (int i = 0; i < SLOTS; i++) start_tick[i] = -1;
    end else if (e) begin
      tick++;
      for (int i = 0; i < SLOTS; i++) begin
        if (start_tick[i] >= 0) begin
          age = tick - start_tick[i];
          if (sb && age >= MIN_DLY && age <= MAX_DLY) begin
            o.mv[i] = 1'b1;
            start_tick[i] = -1;
          end else if (age == MAX_DLY) begin
            o.fv[i] = 1'b1;
            start_tick[i] = -1;
          end
        end
      end
      if (sa) begin
        placed = 0;
        for (int i = 0; i < SLOTS; i++) begin
          if (!placed && start_tick[i] < 0) begin
            start_tick[i] = tick;
            placed = 1;
          end
        end
        o.ov = !placed;
      end
    end
    for (int i = 0; i < SLOTS; i++) o.act[i] = (start_tick[i] >= 0);
    o.m = |o.mv;
    o.f = |o.fv;
    return o;
  endfunction

  task automatic step(
    input logic r, input logic e, input logic sa,
    input logic sb, input logic ab
  );
    @(negedge clk);
    rst_n = r;
    en    = e;
    a     = sa;
    b     = sb;
    abort = ab;
    q.push_back(model_step(r, e, sa, sb, ab));
  endtask

  // monitor: one expected bundle per clock, compared after the edge
  initial begin
    obs_t got;
    obs_t exp;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp = q.pop_front();
        got = '{act: active, mv: match_vec, fv: fail_vec,
                m: match, f: fail, ov: overflow};
        n_vec++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL cyc%0d outputs: got act=%b mv=%b fv=%b m=%b f=%b ov=%b want act=%b mv=%b fv=%b m=%b f=%b ov=%b",
                   n_vec, got.act, got.mv, got.fv, got.m, got.f, got.ov,
                   exp.act, exp.mv, exp.fv, exp.m, exp.f, exp.ov);
        end
      end
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < SLOTS; i++) start_tick[i] = -1;
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0);
    // b too early is ignored, then match at age 2
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    // no b: fail at age MAX
    step(1, 1, 1, 0, 0);
    repeat (5) step(1, 1, 0, 0, 0);
    // a held: fill slots, overflow, same-edge reuse after fail
    repeat (6) step(1, 1, 1, 0, 0);
    repeat (5) step(1, 1, 0, 0, 0);
    // abort with two live attempts; a on abort edge ignored
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 1);
    repeat (2) step(1, 1, 0, 1, 0);
    // freeze mid-window, b during freeze ignored
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    repeat (3) step(1, 0, 1, 1, 0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    // reset mid-window
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(0, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    // random traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(99) >= 2,
           $urandom_range(99) < 85,
           $urandom_range(99) < 50,
           $urandom_range(99) < 30,
           $urandom_range(99) < 3);
    end
    repeat (MAX_DLY + 2) step(1, 1, 0, 0, 0);
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d bundles left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
